menu_sequencer: RTL and testbench



---
 rtl/pocket_pkg.sv | 9 +
 rtl/key_debounce.sv | 31 +++
 rtl/menu_sequencer.sv | 57 +++++
 tb/tb_menu_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pocket_pkg.sv
// pocket_pkg: shared state type, key indices and defaults for the pocket LED board sequencer
package pocket_pkg;
  typedef enum logic [1:0] {MENU, LAUNCH, RUN, EXIT} state_t;
  localparam int KEY_SEL = 0;
  localparam int KEY_NEXT = 1;
  localparam int KEY_PREV = 2;
  localparam int KEY_ABORT = 8;
  localparam int N_APP_DEFAULT = 8;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer, stable-count debouncer and registered rise pulse
module key_debounce #(
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);
  logic [1:0] sync;
  logic level, level_q;
  logic [DEB_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      sync <= '0;
      level <= 1'b0;
      level_q <= 1'b0;
      cnt <= '0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      level_q <= level;
      pulse <= level & ~level_q;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
        level <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/menu_sequencer.sv
// menu_sequencer: browses a cursor over sub-applications and runs the selected one via active-low one-hot enable
module menu_sequencer
  import pocket_pkg::*;
#(
  parameter int N_APP = N_APP_DEFAULT,
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [8:0]               keys,
  input  logic [N_APP-1:0]         en_back,
  output logic [N_APP-1:0]         en_sub,
  output logic [$clog2(N_APP)-1:0] cursor,
  output logic                     in_menu
);
  localparam int CW = $clog2(N_APP);
  state_t state, state_n;
  logic [CW-1:0] active, active_n, cursor_n;
  logic [N_APP-1:0] en_q;
  logic [3:0] raw, p;
  logic done;
  logic unused_keys;
  assign unused_keys = ^keys[7:3];
  assign raw = {keys[KEY_ABORT], keys[KEY_PREV], keys[KEY_NEXT], keys[KEY_SEL]};
  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb (
      .clk(clk), .rst_n(rst_n), .raw(raw[i]), .pulse(p[i])
    );
  end
  always_comb begin
    done = p[3] | (en_back[active] & ~en_q[active]);
    state_n = state == MENU ? (p[0] ? LAUNCH : MENU) :
              state == LAUNCH ? RUN :
              state == RUN ? (done ? EXIT : RUN) : MENU;
    active_n = (state == MENU && p[0]) ? cursor : active;
    cursor_n = (state != MENU || p[0] || p[1] == p[2]) ? cursor :
               p[1] ? cursor + 1'b1 : cursor - 1'b1;
  end
  // en_q samples every cycle, so a done level already high at LAUNCH never looks like a new edge
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= MENU;
      active <= '0;
      cursor <= '0;
      en_q <= '0;
      en_sub <= '1;
      in_menu <= 1'b1;
    end else begin
      state <= state_n;
      active <= active_n;
      cursor <= cursor_n;
      en_q <= en_back;
      en_sub <= state_n == RUN ? ~(N_APP'(1) << active_n) : '1;
      in_menu <= state_n == MENU;
    end
endmodule

// File: tb/tb_menu_sequencer.sv
// tb_menu_sequencer: scoreboard bench comparing output changes against an event-level reference model
module tb_menu_sequencer;
  localparam int D = 4;
  logic clk = 0, rst_n = 0;
  logic [8:0] keys = '0;
  logic [7:0] en_back = '0, en_sub;
  logic [2:0] cursor;
  logic in_menu;
  menu_sequencer #(.N_APP(8), .DEB_CYCLES(D), .DEB_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .en_back(en_back),
    .en_sub(en_sub), .cursor(cursor), .in_menu(in_menu)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; logic [11:0] val;} exp_t;
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  bit started = 0;
  logic [11:0] last_obs, m_last;
  int m_cur = 0, m_act = 0;
  bit m_run = 0;
  logic [7:0] m_back = '0;
  always @(posedge clk) cyc++;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
    end
  endtask
  task automatic push(input int c, input int cur, input logic [7:0] en, input bit im);
    logic [11:0] v;
    v = {cur[2:0], en, im};
    if (v != m_last) q.push_back('{c, v});
    m_last = v;
  endtask
  // a pulse at cycle pc acts on the FSM at the following edge
  task automatic apply(input logic [8:0] m, input int pc);
    if (!m_run) begin
      if (m[0]) begin
        m_act = m_cur;
        m_run = 1;
        push(pc + 1, m_cur, 8'hFF, 0);
        push(pc + 2, m_cur, ~(8'b1 << m_act), 0);
      end else if (m[1] != m[2]) begin
        m_cur = (m_cur + (m[1] ? 1 : 7)) % 8;
        push(pc + 1, m_cur, 8'hFF, 1);
      end
    end else if (m[8]) begin
      m_run = 0;
      push(pc + 1, m_cur, 8'hFF, 0);
      push(pc + 2, m_cur, 8'hFF, 1);
    end
  endtask
  task automatic press(input logic [8:0] m, input int bounce);
    for (int i = 0; i < bounce; i++) begin
      keys = m; step();
      keys = '0; step();
    end
    keys = m;
    apply(m, cyc + 3 + D);
    repeat (D + 8) step();
    keys = '0;
    repeat (D + 8) step();
  endtask
  task automatic set_back(input int b, input bit v);
    en_back[b] = v;
    if (v && !m_back[b] && m_run && b == m_act) begin
      m_run = 0;
      push(cyc + 1, m_cur, 8'hFF, 0);
      push(cyc + 2, m_cur, 8'hFF, 1);
    end
    m_back[b] = v;
    repeat (4) step();
  endtask
  task automatic pulse_reset();
    rst_n = 0;
    m_cur = 0;
    m_run = 0;
    push(cyc + 1, 0, 8'hFF, 1);
    step();
    rst_n = 1;
    repeat (3) step();
  endtask
  always @(negedge clk)
    if (started) begin
      logic [11:0] obs;
      exp_t e;
      obs = {cursor, en_sub, in_menu};
      if (obs !== last_obs) begin
        check("onehot", 32'($countones(~en_sub) <= 1), 32'd1);
        if (q.size() == 0) check("unexpected_change", {20'd0, obs}, {20'd0, last_obs});
        else begin
          e = q.pop_front();
          check("outputs", {20'd0, obs}, {20'd0, e.val});
          check("cycle", cyc, e.cyc);
        end
        last_obs = obs;
      end else if (q.size() != 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        check("timeout", {20'd0, obs}, {20'd0, e.val});
      end
    end
  initial begin
    repeat (3) step();
    rst_n = 1;
    step();
    check("reset_cursor", {29'd0, cursor}, 32'd0);
    check("reset_en_sub", {24'd0, en_sub}, 32'hFF);
    check("reset_in_menu", {31'd0, in_menu}, 32'd1);
    last_obs = {cursor, en_sub, in_menu};
    m_last = {3'd0, 8'hFF, 1'b1};
    started = 1;
    press(9'h002, 1);
    press(9'h004, 0);
    press(9'h004, 0);
    press(9'h002, 0);
    repeat (8) press(9'h002, 0);
    press(9'h006, 0);
    repeat (3) press(9'h002, 0);
    press(9'h003, 0);
    press(9'h100, 0);
    repeat (2) press(9'h002, 0);
    press(9'h001, 0);
    set_back(2, 1);
    press(9'h002, 0);
    set_back(5, 1);
    set_back(2, 0);
    set_back(5, 0);
    set_back(4, 1);
    press(9'h004, 0);
    press(9'h001, 0);
    press(9'h002, 0);
    set_back(4, 0);
    set_back(4, 1);
    press(9'h001, 0);
    press(9'h100, 0);
    set_back(4, 0);
    repeat (2) press(9'h002, 0);
    press(9'h001, 0);
    pulse_reset();
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) begin
        logic [8:0] mk;
        mk = 9'($urandom_range(0, 7));
        mk[8] = ($urandom_range(0, 3) == 0);
        mk[5] = $urandom_range(0, 1);
        press(mk, $urandom_range(0, 2));
      end else if (r < 9) begin
        int b;
        b = $urandom_range(0, 7);
        set_back(b, ~m_back[b]);
      end else pulse_reset();
    end
    repeat (10) step();
    check("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
